adc_stream_packer: RTL and testbench

Parametrised packer between the multi-channel ADC front end and the write side of the DMA async FIFO, entirely in the adc_clk domain. Captures NCH channels of SW-bit samples per valid strobe and applies a channel-enable mask and decimation. Serialises the enabled channels into OW-bit beats with a valid/ready handshake and generates tlast locally, so the DMA side no longer counts beats. Adds abort, overflow detection and done/busy status.

---
 rtl/adc_stream_pkg.sv | 25 ++
 rtl/adc_beat_serializer.sv | 97 +++++++++
 rtl/adc_stream_packer.sv | 166 ++++++++++++++++
 tb/tb_adc_stream_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_stream_pkg.sv
// Shared types and helpers for the ADC stream packer.
package adc_stream_pkg;

  localparam int DEF_NCH      = 4;
  localparam int DEF_SW       = 16;
  localparam int DEF_OW       = 8;
  localparam int BEATS_PER_CH = DEF_SW / DEF_OW;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    ABORT_WAIT = 2'd2
  } state_e;

  // Number of set bits in a channel mask (up to 8 channels).
  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/adc_beat_serializer.sv
// Packs the enabled channels of one sample MSB-aligned and shifts them out
// one OW-bit beat per valid/ready handshake.
module adc_beat_serializer
  import adc_stream_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int SW  = DEF_SW,
  parameter int OW  = DEF_OW
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              load,
  input  logic [NCH*SW-1:0] load_data,
  input  logic [NCH-1:0]    load_mask,
  input  logic              load_last,
  input  logic              force_last,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              final_hs
);

  localparam int BPC   = SW / OW;
  localparam int TOT   = NCH * BPC;
  localparam int CNT_W = $clog2(TOT + 1);

  logic [NCH*SW-1:0] sh_d, sh_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              valid_d, valid_q;
  logic              last_d, last_q;
  logic [NCH*SW-1:0] pack_word;
  logic [CNT_W-1:0]  beats_total;
  logic              hs;
  int                pos;

  // Compact enabled channels, ch1 first, into the top of the shift word.
  always_comb begin
    pack_word = '0;
    pos       = 0;
    for (int i = 0; i < NCH; i++) begin
      if (load_mask[i]) begin
        pack_word[NCH*SW-1-pos*SW -: SW] = load_data[(NCH-i)*SW-1 -: SW];
        pos++;
      end
    end
    beats_total = CNT_W'(popcount(8'(load_mask)) * BPC);
  end

  assign hs        = valid_q && out_ready;
  assign final_hs  = hs && (cnt_q == CNT_W'(1));
  assign out_data  = sh_q[NCH*SW-1 -: OW];
  assign out_valid = valid_q;
  assign out_last  = valid_q && last_q && (cnt_q == CNT_W'(1));

  // Load a new sample, or advance one beat on each handshake.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      sh_d    = pack_word;
      cnt_d   = beats_total;
      valid_d = 1'b1;
      last_d  = load_last;
    end else begin
      if (force_last && valid_q) begin
        last_d = 1'b1;
      end
      if (hs) begin
        sh_d  = sh_q << OW;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
    end
  end

  // Serialiser state registers.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/adc_stream_packer.sv
// Packet controller between the ADC front end and the DMA FIFO write side:
// decimation, sample counting, abort handling and status.
module adc_stream_packer
  import adc_stream_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int SW    = DEF_SW,
  parameter int OW    = DEF_OW,
  parameter int LEN_W = 32,
  parameter int DEC_W = 16
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              sample_start,
  input  logic              sample_abort,
  input  logic [LEN_W-1:0]  sample_len,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [DEC_W-1:0]  decim,
  input  logic              in_valid,
  input  logic [NCH*SW-1:0] in_data,
  output logic [OW-1:0]     out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  if (SW % OW != 0) begin : g_bad_width
    $error("SW must be a multiple of OW");
  end
  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("NCH must be in 1..8");
  end

  state_e             state_d, state_q;
  logic [LEN_W-1:0]   len_d, len_q, scnt_d, scnt_q;
  logic [NCH-1:0]     mask_d, mask_q;
  logic [DEC_W-1:0]   dec_d, dec_q, dcnt_d, dcnt_q;
  logic               overflow_d, overflow_q;
  logic               done_d, done_q;
  logic               ser_load, ser_load_last, ser_force_last, ser_final_hs;
  logic               kept, can_load, pkt_end;

  assign kept     = in_valid && (dcnt_q == '0);
  assign can_load = !out_valid || ser_final_hs;
  assign pkt_end  = ser_final_hs && out_last;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;

  // Next-state, decimation, capture and status decisions.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    mask_d         = mask_q;
    dec_d          = dec_q;
    dcnt_d         = dcnt_q;
    scnt_d         = scnt_q;
    overflow_d     = overflow_q;
    done_d         = 1'b0;
    ser_load       = 1'b0;
    ser_load_last  = 1'b0;
    ser_force_last = 1'b0;
    if (state_q != IDLE && in_valid) begin
      dcnt_d = (dcnt_q == dec_q) ? '0 : dcnt_q + DEC_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (!sample_abort && sample_start) begin
          overflow_d = 1'b0;
          if (sample_len == '0 || ch_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            len_d   = sample_len;
            mask_d  = ch_mask;
            dec_d   = decim;
            dcnt_d  = '0;
            scnt_d  = '0;
          end
        end
      end
      RUN: begin
        if (pkt_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (sample_abort) begin
          if (out_valid && !ser_final_hs) begin
            ser_force_last = 1'b1;
            state_d        = ABORT_WAIT;
          end else if (scnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ser_load      = kept;
            ser_load_last = 1'b1;
            state_d       = ABORT_WAIT;
          end
        end else if (kept && scnt_q != len_q) begin
          if (can_load) begin
            ser_load      = 1'b1;
            ser_load_last = (scnt_q + LEN_W'(1) == len_q);
            scnt_d        = scnt_q + LEN_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      ABORT_WAIT: begin
        if (pkt_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (kept && can_load) begin
          ser_load      = 1'b1;
          ser_load_last = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      mask_q     <= '0;
      dec_q      <= '0;
      dcnt_q     <= '0;
      scnt_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      dec_q      <= dec_d;
      dcnt_q     <= dcnt_d;
      scnt_q     <= scnt_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  adc_beat_serializer #(
    .NCH (NCH),
    .SW  (SW),
    .OW  (OW)
  ) u_ser (
    .adc_clk    (adc_clk),
    .adc_rst_n  (adc_rst_n),
    .load       (ser_load),
    .load_data  (in_data),
    .load_mask  (mask_q),
    .load_last  (ser_load_last),
    .force_last (ser_force_last),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .final_hs   (ser_final_hs)
  );

endmodule

// File: tb/tb_adc_stream_packer.sv
// Directed scenario table plus reset sequences for adc_stream_packer.
module tb_adc_stream_packer;

  localparam int NCH = 4, SW = 16, OW = 8, LEN_W = 32, DEC_W = 16;

  logic              adc_clk = 1'b0;
  logic              adc_rst_n = 1'b0;
  logic              sample_start = 1'b0, sample_abort = 1'b0;
  logic [LEN_W-1:0]  sample_len = '0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [DEC_W-1:0]  decim = '0;
  logic              in_valid = 1'b0;
  logic [NCH*SW-1:0] in_data = '0;
  logic [OW-1:0]     out_data;
  logic              out_valid, out_last, busy, done, overflow;
  logic              out_ready = 1'b1;

  always #5 adc_clk = ~adc_clk;

  adc_stream_packer #(.NCH(NCH), .SW(SW), .OW(OW), .LEN_W(LEN_W), .DEC_W(DEC_W)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .sample_start(sample_start),
    .sample_abort(sample_abort), .sample_len(sample_len), .ch_mask(ch_mask),
    .decim(decim), .in_valid(in_valid), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] len;
    logic [15:0] dec;
    int          vper;
    int          nval;
    bit          rdy3;
    int          abort_cyc;
    bit          start_abort;
    bit          poke;
    int          exp_beats;
    int          exp_samp;
    bit          exp_ovf;
    bit          exp_done;
    int          exp_done_cyc;
    bit          dchk;
  } scn_t;

  scn_t tbl[10];
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic logic [15:0] ch_val(input int j, input int c);
    logic [15:0] base;
    logic [3:0]  jn;
    case (c)
      1:       base = 16'h1122;
      2:       base = 16'h3344;
      3:       base = 16'h5566;
      default: base = 16'h7788;
    endcase
    jn = 4'(j);
    return base ^ {jn, 12'h000};
  endfunction

  function automatic logic [NCH*SW-1:0] sample_word(input int j);
    return {ch_val(j, 1), ch_val(j, 2), ch_val(j, 3), ch_val(j, 4)};
  endfunction

  task automatic run_scn(input scn_t s, input int idx);
    logic [7:0] exp_q[$];
    logic [15:0] v;
    logic [7:0] prev_data;
    logic prev_last, prev_stall;
    int kept, cyc, j, b, done_cnt, done_cyc, last_hs_cyc, min_cyc;
    exp_q = {};
    kept = 0;
    for (int jj = 0; kept < s.exp_samp && jj < 64; jj++) begin
      if (jj % (int'(s.dec) + 1) == 0) begin
        kept++;
        for (int c = 1; c <= NCH; c++) begin
          if (s.mask[c-1]) begin
            v = ch_val(jj, c);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
          end
        end
      end
    end
    @(posedge adc_clk); #1;
    sample_start = 1'b1; sample_abort = s.start_abort;
    sample_len = s.len; ch_mask = s.mask; decim = s.dec;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0; j = 0; b = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    min_cyc = s.nval * s.vper + 5;
    while (cyc < min_cyc || (s.exp_done && (done_cnt == 0 || cyc < done_cyc + 4) && cyc < 400)) begin
      @(posedge adc_clk); #1;
      sample_start = s.poke && (cyc == 12);
      sample_abort = (cyc == s.abort_cyc);
      sample_len = 32'd1; ch_mask = 4'b0010; decim = 16'd5;
      in_valid = 1'b0;
      in_data = {$urandom, $urandom};
      if (j < s.nval && (cyc % s.vper) == s.vper - 1) begin
        in_valid = 1'b1;
        in_data = sample_word(j);
        j++;
      end
      out_ready = s.rdy3 ? (cyc % 3 == 0) : 1'b1;
      @(negedge adc_clk);
      if (cyc == 0) begin
        chk($sformatf("s%0d_busy_after_start", idx), 32'(busy),
            32'(s.mask != 0 && s.len != 0 && !s.start_abort));
        chk($sformatf("s%0d_ovf_after_start", idx), 32'(overflow), 32'd0);
      end
      if (prev_stall) begin
        chk($sformatf("s%0d_c%0d_stall_hold", idx, cyc), {22'd0, out_valid, out_last, out_data},
            {22'd0, 1'b1, prev_last, prev_data});
      end
      if (out_valid && out_ready) begin
        chk($sformatf("s%0d_beat%0d_last", idx, b), 32'(out_last), 32'(b + 1 == s.exp_beats));
        if (s.dchk && b < exp_q.size()) begin
          chk($sformatf("s%0d_beat%0d_data", idx, b), 32'(out_data), 32'(exp_q[b]));
        end
        if (out_last) last_hs_cyc = cyc;
        b++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      cyc++;
    end
    chk($sformatf("s%0d_beats", idx), 32'(b), 32'(s.exp_beats));
    chk($sformatf("s%0d_overflow", idx), 32'(overflow), 32'(s.exp_ovf));
    chk($sformatf("s%0d_busy_end", idx), 32'(busy), 32'd0);
    chk($sformatf("s%0d_done_pulses", idx), 32'(done_cnt), 32'(s.exp_done));
    if (s.exp_done) begin
      chk($sformatf("s%0d_done_cycle", idx), 32'(done_cyc),
          32'(s.exp_done_cyc >= 0 ? s.exp_done_cyc : last_hs_cyc + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          mask   len     dec   vper nval rdy3 abort st_ab poke beats samp ovf  done dcyc dchk
    tbl[0] = '{4'hF, 32'd3,   16'd0, 10, 3,  1'b0, -1, 1'b0, 1'b1, 24, 3, 1'b0, 1'b1, -1, 1'b1};
    tbl[1] = '{4'h5, 32'd2,   16'd2, 5,  9,  1'b0, -1, 1'b0, 1'b0, 8,  2, 1'b0, 1'b1, -1, 1'b1};
    tbl[2] = '{4'hF, 32'd3,   16'd0, 4,  30, 1'b1, -1, 1'b0, 1'b0, 24, 3, 1'b1, 1'b1, -1, 1'b0};
    tbl[3] = '{4'hF, 32'd3,   16'd0, 8,  3,  1'b0, -1, 1'b0, 1'b0, 24, 3, 1'b0, 1'b1, -1, 1'b1};
    tbl[4] = '{4'hF, 32'd100, 16'd0, 10, 2,  1'b0, 23, 1'b0, 1'b0, 16, 2, 1'b0, 1'b1, -1, 1'b1};
    tbl[5] = '{4'hF, 32'd5,   16'd0, 10, 2,  1'b0, 2,  1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 3,  1'b0};
    tbl[6] = '{4'hF, 32'd0,   16'd0, 10, 1,  1'b0, -1, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 0,  1'b0};
    tbl[7] = '{4'h0, 32'd3,   16'd0, 10, 1,  1'b0, -1, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1, 0,  1'b0};
    tbl[8] = '{4'hF, 32'd3,   16'd0, 10, 2,  1'b0, -1, 1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 0,  1'b0};
    tbl[9] = '{4'hF, 32'd1,   16'd0, 10, 1,  1'b0, -1, 1'b0, 1'b0, 8,  1, 1'b0, 1'b1, -1, 1'b1};

    repeat (3) @(negedge adc_clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    adc_rst_n = 1'b1;
    @(negedge adc_clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) run_scn(tbl[i], i);

    // Reset in the middle of a packet.
    @(posedge adc_clk); #1;
    sample_start = 1'b1; sample_abort = 1'b0; sample_len = 32'd5; ch_mask = 4'hF;
    decim = '0; out_ready = 1'b1;
    @(posedge adc_clk); #1;
    sample_start = 1'b0; in_valid = 1'b1; in_data = sample_word(0);
    @(posedge adc_clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge adc_clk);
    #2;
    chk("midrst_pre_valid", 32'(out_valid), 32'd1);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    #1 adc_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge adc_clk);
    adc_rst_n = 1'b1;
    repeat (3) @(negedge adc_clk);
    chk("midrst_after_valid", 32'(out_valid), 32'd0);
    chk("midrst_after_busy", 32'(busy), 32'd0);

    run_scn(tbl[9], 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
